phase_sequencer: RTL

- Multi-cycle phase generator and run/stop controller for the processor.
- Drives the 3-bit `phase` bus consumed by control_combination: 0 = stopped, 1..N = execution phases of one instruction.
- Handles the exec push-button toggle (start/stop), single-step mode, HLT, variable-length instructions and a retired-instruction counter.
- Sits at top level between the board inputs and the control decoder.

---
 rtl/phase_sequencer_pkg.sv | 21 ++
 rtl/phase_sequencer_if.sv | 24 ++
 rtl/phase_sequencer_edge_detect.sv | 16 +
 rtl/phase_sequencer.sv | 91 +++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared phase encoding and sequencer state for phase_sequencer and control_combination.
package phase_sequencer_pkg;

    localparam logic [2:0] PH_IDLE       = 3'd0;
    localparam logic [2:0] PH_FETCH      = 3'd1;
    localparam int         MAX_PHASE_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

    // Out-of-range decoder lengths fall back to the longest instruction.
    function automatic logic [2:0] eff_last_f(input logic [2:0] lp, input int max_phase);
        if (lp == 3'd0 || int'(lp) > max_phase)
            return 3'(max_phase);
        return lp;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Board/decoder-facing signal bundle of the phase sequencer.
interface phase_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             exec;
    logic             step_mode;
    logic [2:0]       last_phase;
    logic             halt;
    logic [2:0]       phase;
    logic             running;
    logic             halted;
    logic             instr_done;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output exec, step_mode, last_phase, halt,
        input  phase, running, halted, instr_done, instr_count
    );

    modport slave (
        input  exec, step_mode, last_phase, halt,
        output phase, running, halted, instr_done, instr_count
    );
endinterface

// File: rtl/phase_sequencer_edge_detect.sv
// 1-bit rising-edge detector; the pulse is combinational against the registered level.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;
endmodule

// File: rtl/phase_sequencer.sv
// Phase generator and run/stop controller: steps phase 1..last_phase per instruction.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int MAX_PHASE = MAX_PHASE_DEF,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic rst,
    phase_sequencer_if.slave bus
);
    seq_state_e       state;
    logic [2:0]       phase_q;
    logic             running_q;
    logic             halted_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stop_req;
    logic             exec_rise;
    logic [2:0]       eff_last;
    logic             retire;

    edge_detect u_exec_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.exec),
        .rise (exec_rise)
    );

    assign eff_last = eff_last_f(bus.last_phase, MAX_PHASE);
    // >= so a length shrinking below the current phase retires right away
    assign retire   = (state == ST_RUN) && (phase_q >= eff_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_q   <= PH_IDLE;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            stop_req  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (exec_rise) begin
                        state     <= ST_RUN;
                        phase_q   <= PH_FETCH;
                        running_q <= 1'b1;
                        stop_req  <= bus.step_mode;
                    end
                end
                ST_RUN: begin
                    if (retire) begin
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        if (bus.halt) begin
                            state     <= ST_HALTED;
                            phase_q   <= PH_IDLE;
                            running_q <= 1'b0;
                            halted_q  <= 1'b1;
                        end else if (stop_req || exec_rise) begin
                            state     <= ST_IDLE;
                            phase_q   <= PH_IDLE;
                            running_q <= 1'b0;
                            stop_req  <= 1'b0;
                        end else begin
                            phase_q <= PH_FETCH;
                        end
                    end else begin
                        phase_q <= phase_q + 3'd1;
                        if (exec_rise) stop_req <= 1'b1;
                    end
                end
                ST_HALTED: ;
                default: begin
                    state     <= ST_IDLE;
                    phase_q   <= PH_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase       = phase_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.instr_done  = done_q;
    assign bus.instr_count = cnt_q;
endmodule
